seven_seg_scanner: RTL
======================

// Module: seven_seg_scanner
// PURPOSE
//  Parametrised multiplexed 7-segment display driver for any digit count, replacing the fixed 8-digit scanner.
//  Scans NUM_DIGITS hex digits with per-digit decimal point, per-digit blanking, leading-zero suppression and PWM brightness.
//  Uses a tear-free shadow-register update: new data is latched on load_in and applied only at a frame boundary.
//  Sits between game/debug logic and the board's common-anode display pins.
// PARAMETERS
//  NUM_DIGITS  8       digits scanned, 1..16; digit 0 = rightmost = val_in[3:0]
//  SCAN_DIV    25000   clk_in cycles per digit slot, >= 2**BRIGHT_W
//  BRIGHT_W    4       brightness control width
// PORTS
//  clk_in          in   1              system clock; all logic on posedge
//  rst_in          in   1              synchronous reset, ACTIVE-LOW (0 = reset)
//  val_in          in   4*NUM_DIGITS   hex nibbles, digit k = val_in[4k+3:4k]
//  dp_in           in   NUM_DIGITS     decimal point on, per digit
//  blank_in        in   NUM_DIGITS     force digit dark, per digit
//  lz_en_in        in   1              leading-zero suppression enable
//  brightness_in   in   BRIGHT_W       duty control; all-ones = fully on
//  load_in         in   1              1-cycle strobe: capture all inputs above into pending regs
//  cat_out         out  7              cathodes {g,f,e,d,c,b,a}, active-low
//  dp_out          out  1              decimal-point cathode, active-low
//  an_out          out  NUM_DIGITS     anodes, active-low, at most one low
//  frame_done_out  out  1              1-cycle pulse when digit NUM_DIGITS-1 slot ends
// BEHAVIOUR
//  Reset (rst_in=0 at posedge): an_out all 1, cat_out 7'h7F, dp_out 1, frame_done_out 0; tick=0, idx=0.
//   Active regs: val 0, dp 0, blank 0, lz 0, brightness all-ones. Pending flag cleared, pending data discarded.
//   Reset mid-frame has the same effect; the scan restarts at digit 0.
//  Scan: tick counts 0..SCAN_DIV-1. At tick==SCAN_DIV-1, tick wraps to 0 and idx advances (NUM_DIGITS-1 -> 0).
//  Frame boundary: the cycle where tick==SCAN_DIV-1 and idx==NUM_DIGITS-1.
//   On that cycle, frame_done_out=1 on the next cycle (registered).
//   On that cycle, if the pending flag is set, active <= pending and the flag clears.
//  load_in: pending <= {val,dp,blank,lz,brightness}; pending flag <= 1; a later load overwrites pending.
//   load_in on the boundary cycle: the old pending (if any) becomes active now; the new data waits one full frame.
//  Per-slot digit k = idx: lit = ~blank[k] & ~lzs[k] & pwm_on.
//   lzs[k] = lz_en & (k != 0) & (active nibbles k..NUM_DIGITS-1 all zero); digit 0 is never suppressed.
//   pwm_on = (brightness == all-ones) | (tick[BRIGHT_W-1:0] < brightness); brightness 0 = dark.
//  Outputs registered, 1-cycle latency from (tick, idx):
//   an_out: bit idx is 0 when lit; all other bits are 1.
//   cat_out: ~glyph(nibble[idx]) when lit, else 7'h7F.
//   dp_out: ~dp[idx] when lit, else 1.
//  Glyphs (a=bit0) for 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//  Unused inputs at non-boundary cycles do not affect the display (only active regs drive outputs).
// TESTING  (NUM_DIGITS=4, SCAN_DIV=8, BRIGHT_W=2 unless noted)
//  1. Reset, then load val=16'h12AF, bright=3.
//     -> After the first frame_done: an_out 1110,1101,1011,0111, 8 cycles each.
//     -> cat_out ~71,~77,~5B,~06 respectively.
//  2. Load during digit 1 of a frame.
//     -> Outputs unchanged until the boundary; new data appears in the next digit-0 slot.
//     -> Load exactly on the boundary cycle: data appears one frame later.
//  3. lz_en=1, val=16'h0050.
//     -> Digits 3 and 2 dark (an bits 1); digit 1 shows 6D; digit 0 shows 3F.
//     -> With val=0, only digit 0 is lit.
//  4. bright=1: each slot has an anode low on ticks 0 and 4 only (2/8 duty).
//     -> bright=0: an_out stays all-ones; bright=3: low for all 8 ticks.
//  5. blank=4'b0100, dp=4'b0001.
//     -> Digit 2 never lit; dp_out=0 only in the digit-0 slot.
//     -> frame_done pulses exactly every 32 cycles.
//  6. Drive rst_in=0 for 1 cycle mid digit 2 with a pending load.
//     -> Next cycle: reset output values; pending discarded.
//     -> Scan resumes at digit 0 showing 0.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment scanner with shadowed display data,
// leading-zero suppression, per-digit blanking and PWM brightness.
module seven_seg_scanner #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned SCAN_DIV   = 25000,
   parameter int unsigned BRIGHT_W   = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [4*NUM_DIGITS-1:0] val_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_en_in,
   input  logic [BRIGHT_W-1:0]     brightness_in,
   input  logic                    load_in,
   output logic [6:0]              cat_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done_out
);

   localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [TICK_W-1:0] TickLast = TICK_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IdxLast  = IDX_W'(NUM_DIGITS - 1);

   logic [TICK_W-1:0]       tick_q;
   logic [IDX_W-1:0]        idx_q;

   logic [4*NUM_DIGITS-1:0] act_val_q,   pend_val_q;
   logic [NUM_DIGITS-1:0]   act_dp_q,    pend_dp_q;
   logic [NUM_DIGITS-1:0]   act_blank_q, pend_blank_q;
   logic                    act_lz_q,    pend_lz_q;
   logic [BRIGHT_W-1:0]     act_bright_q, pend_bright_q;
   logic                    pend_vld_q;

   logic                    slot_end, boundary;
   logic [NUM_DIGITS-1:0]   upper_zero;
   logic [3:0]              cur_nib;
   logic                    lzs, pwm_on, lit;
   logic [NUM_DIGITS-1:0]   an_d;
   logic [6:0]              cat_d;
   logic                    dp_d;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      unique case (nib)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         4'hF: glyph = 7'h71;
      endcase
   endfunction

   assign slot_end = (tick_q == TickLast);
   assign boundary = slot_end && (idx_q == IdxLast);

   // upper_zero[k]: active nibbles k..NUM_DIGITS-1 are all zero
   always_comb begin
      logic run;
      run        = 1'b1;
      upper_zero = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         run           = run && (act_val_q[4*k +: 4] == 4'h0);
         upper_zero[k] = run;
      end
   end

   always_comb begin
      cur_nib = act_val_q[4*idx_q +: 4];
      lzs     = act_lz_q && (idx_q != '0) && upper_zero[idx_q];
      pwm_on  = (&act_bright_q) || (tick_q[BRIGHT_W-1:0] < act_bright_q);
      lit     = !act_blank_q[idx_q] && !lzs && pwm_on;
      an_d    = '1;
      cat_d   = 7'h7F;
      dp_d    = 1'b1;
      if (lit) begin
         an_d[idx_q] = 1'b0;
         cat_d       = ~glyph(cur_nib);
         dp_d        = ~act_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         tick_q         <= '0;
         idx_q          <= '0;
         act_val_q      <= '0;
         act_dp_q       <= '0;
         act_blank_q    <= '0;
         act_lz_q       <= 1'b0;
         act_bright_q   <= '1;
         pend_val_q     <= '0;
         pend_dp_q      <= '0;
         pend_blank_q   <= '0;
         pend_lz_q      <= 1'b0;
         pend_bright_q  <= '0;
         pend_vld_q     <= 1'b0;
         an_out         <= '1;
         cat_out        <= 7'h7F;
         dp_out         <= 1'b1;
         frame_done_out <= 1'b0;
      end else begin
         if (slot_end) begin
            tick_q <= '0;
            idx_q  <= boundary ? '0 : idx_q + 1'b1;
         end else begin
            tick_q <= tick_q + 1'b1;
         end

         if (boundary && pend_vld_q) begin
            act_val_q    <= pend_val_q;
            act_dp_q     <= pend_dp_q;
            act_blank_q  <= pend_blank_q;
            act_lz_q     <= pend_lz_q;
            act_bright_q <= pend_bright_q;
            pend_vld_q   <= 1'b0;
         end

         // A load on the boundary overrides the flag clear above; its data waits a frame
         if (load_in) begin
            pend_val_q    <= val_in;
            pend_dp_q     <= dp_in;
            pend_blank_q  <= blank_in;
            pend_lz_q     <= lz_en_in;
            pend_bright_q <= brightness_in;
            pend_vld_q    <= 1'b1;
         end

         an_out         <= an_d;
         cat_out        <= cat_d;
         dp_out         <= dp_d;
         frame_done_out <= boundary;
      end
   end

endmodule
